// File: rtl/tick_divider_bank_if.sv
// tick_divider_bank_if: control/status bundle for the tick divider bank.
//   en      - global count enable (low freezes every channel)
//   sync    - global phase align (clears every channel counter and output)
//   sel     - per-channel shift select; half-period = CLK_HZ >> sel
//   clk_out - per-channel divided square wave
//   tick    - per-channel one-cycle pulse on every clk_out edge
//   count   - per-channel current counter value
// master: the block that drives the controls; slave: the divider bank.
interface tick_divider_bank_if #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 5,
    parameter int CNT_W  = 32
);
    logic                             en;
    logic                             sync;
    logic [NUM_CH-1:0][SEL_W-1:0]     sel;
    logic [NUM_CH-1:0]                clk_out;
    logic [NUM_CH-1:0]                tick;
    logic [NUM_CH-1:0][CNT_W-1:0]     count;

    modport master (output en, sync, sel, input clk_out, tick, count);
    modport slave  (input en, sync, sel, output clk_out, tick, count);
endinterface

// File: rtl/tick_divider_bank.sv
// tick_divider_bank: NUM_CH independent programmable dividers.
// Each channel counts 0..half_n-1, then toggles its square wave and pulses
// tick for one cycle. half_n = CLK_HZ >> sel (clamped to at least 1).
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   bus - tick_divider_bank_if slave (en, sync, sel in; clk_out, tick, count out)

// One divider channel.
module tick_divider_lane #(
    parameter int CLK_HZ = 100000000,
    parameter int SEL_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic [CNT_W-1:0] count_o
);
    localparam logic [CNT_W-1:0] BASE_N = CNT_W'(CLK_HZ);

    logic [CNT_W-1:0] shifted;
    logic [CNT_W-1:0] half_n;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic [SEL_W-1:0] sel_q;

    // Large shifts underflow to 0; a zero half-period would never wrap.
    always_comb begin
        shifted = BASE_N >> sel_i;
        half_n  = (shifted == '0) ? CNT_W'(1) : shifted;
    end

    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        tick_d = 1'b0;
        if (sync_i) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else if (sel_i != sel_q) begin
            // Restart on the new period; level is kept so no glitch edge.
            cnt_d = '0;
        end else if (!en_i) begin
            cnt_d = cnt_q;
        end else if (cnt_q >= half_n - CNT_W'(1)) begin
            // >= rather than == guards against a stale count above half_n.
            cnt_d  = '0;
            out_d  = ~out_q;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // sel_q always follows sel, so the cycle after reset never sees a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
            sel_q  <= sel_i;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            tick_q <= tick_d;
            sel_q  <= sel_i;
        end
    end

    assign clk_out_o = out_q;
    assign tick_o    = tick_q;
    assign count_o   = cnt_q;
endmodule

module tick_divider_bank #(
    parameter int CLK_HZ = 100000000,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    tick_divider_bank_if.slave  bus
);
    logic [NUM_CH-1:0]            clk_out_w;
    logic [NUM_CH-1:0]            tick_w;
    logic [NUM_CH-1:0][CNT_W-1:0] count_w;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        tick_divider_lane #(
            .CLK_HZ (CLK_HZ),
            .SEL_W  (SEL_W),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en_i      (bus.en),
            .sync_i    (bus.sync),
            .sel_i     (bus.sel[g]),
            .clk_out_o (clk_out_w[g]),
            .tick_o    (tick_w[g]),
            .count_o   (count_w[g])
        );
    end

    assign bus.clk_out = clk_out_w;
    assign bus.tick    = tick_w;
    assign bus.count   = count_w;
endmodule

// File: tb/tb_tick_divider_bank.sv
module tb_tick_divider_bank;
    localparam int CLK_HZ = 16;
    localparam int NUM_CH = 2;
    localparam int SEL_W  = 5;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tick_divider_bank_if #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

    tick_divider_bank #(.CLK_HZ(CLK_HZ), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: elapsed enabled cycles since the last restart plus
    // the level held at that restart; outputs follow by division.
    int              t_el [NUM_CH];
    bit              base [NUM_CH];
    bit              mtick[NUM_CH];
    logic [SEL_W-1:0] sq  [NUM_CH];
    bit              mcheck = 1'b1;

    function automatic int half(input logic [SEL_W-1:0] s);
        int v = CLK_HZ >> s;
        return (v == 0) ? 1 : v;
    endfunction

    function automatic bit mlvl(input int c);
        return base[c] ^ bit'((t_el[c] / half(sq[c])) % 2);
    endfunction

    function automatic void model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            mtick[c] = 1'b0;
            if (rst || bus.sync) begin
                t_el[c] = 0;
                base[c] = 1'b0;
            end else if (bus.sel[c] != sq[c]) begin
                base[c] = mlvl(c);
                t_el[c] = 0;
            end else if (bus.en) begin
                t_el[c]++;
                if (t_el[c] % half(sq[c]) == 0) mtick[c] = 1'b1;
            end
            sq[c] = bus.sel[c];
        end
    endfunction

    task automatic model_cmp();
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("mdl_out%0d", c),  bus.clk_out[c], mlvl(c));
            chk($sformatf("mdl_tick%0d", c), bus.tick[c],    mtick[c]);
            chk($sformatf("mdl_cnt%0d", c),  bus.count[c],   t_el[c] % half(sq[c]));
        end
    endtask

    // Inputs change at negedge; model advances on the posedge; outputs
    // are sampled at the following negedge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (mcheck) model_cmp();
    endtask

    typedef struct {
        logic rst, en, sync;
        logic [SEL_W-1:0] s0, s1;
        logic [1:0] out, tk;
        int c0, c1;
    } vec_t;

    vec_t tbl[14];
    bit   prev;

    initial begin
        // ch0 sel=3 -> half 2, ch1 sel=4 -> half 1; {ch1,ch0} bit order
        tbl[0]  = '{1, 0, 0, 3, 4, 2'b00, 2'b00, 0, 0};
        tbl[1]  = '{0, 1, 0, 3, 4, 2'b10, 2'b10, 1, 0};
        tbl[2]  = '{0, 1, 0, 3, 4, 2'b01, 2'b11, 0, 0};
        tbl[3]  = '{0, 0, 0, 3, 4, 2'b01, 2'b00, 0, 0};
        tbl[4]  = '{0, 1, 0, 3, 4, 2'b11, 2'b10, 1, 0};
        tbl[5]  = '{0, 1, 1, 3, 4, 2'b00, 2'b00, 0, 0};
        tbl[6]  = '{0, 1, 0, 2, 4, 2'b10, 2'b10, 0, 0};
        tbl[7]  = '{0, 1, 0, 2, 4, 2'b00, 2'b10, 1, 0};
        tbl[8]  = '{0, 1, 0, 2, 4, 2'b10, 2'b10, 2, 0};
        tbl[9]  = '{0, 1, 0, 2, 4, 2'b00, 2'b10, 3, 0};
        tbl[10] = '{0, 1, 0, 2, 4, 2'b11, 2'b11, 0, 0};
        tbl[11] = '{0, 0, 0, 3, 4, 2'b11, 2'b00, 0, 0};
        tbl[12] = '{1, 1, 0, 3, 4, 2'b00, 2'b00, 0, 0};
        tbl[13] = '{0, 1, 0, 3, 4, 2'b10, 2'b10, 1, 0};

        rst = 1'b1; bus.en = 1'b0; bus.sync = 1'b0; bus.sel = '0;
        @(negedge clk);

        // Table vectors: one edge each, checked against constants.
        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst; bus.en = tbl[i].en; bus.sync = tbl[i].sync;
            bus.sel[0] = tbl[i].s0; bus.sel[1] = tbl[i].s1;
            step();
            chk($sformatf("tbl%0d_out", i),  bus.clk_out,  tbl[i].out);
            chk($sformatf("tbl%0d_tick", i), bus.tick,     tbl[i].tk);
            chk($sformatf("tbl%0d_c0", i),   bus.count[0], tbl[i].c0);
            chk($sformatf("tbl%0d_c1", i),   bus.count[1], tbl[i].c1);
        end

        // Basic periods: ch0 half 16, ch1 half 4.
        rst = 1'b1; bus.sel[0] = 0; bus.sel[1] = 2; bus.en = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("basic_c0",   bus.count[0], (i == 16) ? 0 : i);
            chk("basic_t0",   bus.tick[0],  i == 16);
            chk("basic_o0",   bus.clk_out[0], i == 16);
            chk("basic_t1",   bus.tick[1],  (i % 4) == 0);
        end

        // sel change at count 10: restart, level held, new half 4.
        repeat (10) step();
        chk("selchg_pre_c0", bus.count[0], 10);
        bus.sel[0] = 2;
        step();
        chk("selchg_c0", bus.count[0], 0);
        chk("selchg_o0", bus.clk_out[0], 1);
        chk("selchg_t0", bus.tick[0], 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("selchg_tk", bus.tick[0], k == 4);
        end
        chk("selchg_o0_post", bus.clk_out[0], 0);

        // en freeze at count 5.
        bus.sel[0] = 0;
        step();
        repeat (5) step();
        chk("frz_c0", bus.count[0], 5);
        prev = bus.clk_out[0];
        bus.en = 1'b0;
        repeat (7) begin
            step();
            chk("frz_hold_c0", bus.count[0], 5);
            chk("frz_hold_t0", bus.tick[0], 0);
            chk("frz_hold_o0", bus.clk_out[0], prev);
        end
        bus.en = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            chk("frz_run_t0", bus.tick[0], k == 11);
            if (k < 11) chk("frz_run_c0", bus.count[0], 5 + k);
        end
        chk("frz_run_o0", bus.clk_out[0], !prev);

        // half_n = 1 (sel 4) and clamped (sel 5).
        for (int s = 4; s <= 5; s++) begin
            bus.sel[0] = SEL_W'(s);
            step();
            chk("fast_restart_t0", bus.tick[0], 0);
            repeat (4) begin
                prev = bus.clk_out[0];
                step();
                chk("fast_t0", bus.tick[0], 1);
                chk("fast_c0", bus.count[0], 0);
                chk("fast_o0", bus.clk_out[0], !prev);
            end
        end

        // Phase align with sync.
        bus.sel[0] = 1; bus.sel[1] = 3;
        repeat (5) step();
        bus.sel[1] = 1;
        repeat (3) step();
        bus.sync = 1'b1;
        step();
        chk("sync_out", bus.clk_out, 2'b00);
        chk("sync_c0", bus.count[0], 0);
        chk("sync_c1", bus.count[1], 0);
        bus.sync = 1'b0;
        repeat (20) begin
            step();
            chk("sync_align_o", bus.clk_out[0], bus.clk_out[1]);
            chk("sync_align_t", bus.tick[0], bus.tick[1]);
        end

        // rst mid-period with clk_out high.
        bus.sel[0] = 0;
        begin
            bit found = 1'b0;
            for (int k = 0; k < 48 && !found; k++) begin
                step();
                if (bus.clk_out[0] && bus.count[0] > 3) found = 1'b1;
            end
            chk("rst_setup_found", found, 1);
        end
        rst = 1'b1;
        step();
        chk("rst_o", bus.clk_out, 2'b00);
        chk("rst_t", bus.tick, 2'b00);
        chk("rst_c0", bus.count[0], 0);
        rst = 1'b0;
        step();
        chk("rst_rel_c0", bus.count[0], 1);

        // Randomized run against the model.
        repeat (2000) begin
            rst      = ($urandom_range(0, 199) == 0);
            bus.sync = ($urandom_range(0, 99) == 0);
            bus.en   = ($urandom_range(0, 9) < 8);
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 39) == 0) bus.sel[c] = SEL_W'($urandom_range(0, 7));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
